// File: rtl/pixel_write_packer.sv
// Merges byte-addressed pixel writes into bus words with byteenables and
// queues completed words for an Avalon-MM master write port.
module pixel_write_packer #(
  parameter int PIXEL_WIDTH = 16,
  parameter int BUS_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [ADDR_WIDTH-1:0]  pix_addr,
  input  logic [PIXEL_WIDTH-1:0] pix_color,
  input  logic                   flush,
  output logic                   idle,
  output logic                   avm_write,
  output logic [ADDR_WIDTH-1:0]  avm_address,
  output logic [BUS_WIDTH-1:0]   avm_writedata,
  output logic [BUS_WIDTH/8-1:0] avm_byteenable,
  input  logic                   avm_waitrequest
);

  localparam int BYTES  = BUS_WIDTH / 8;
  localparam int PBYTES = PIXEL_WIDTH / 8;
  localparam int WOFF   = $clog2(BYTES);
  localparam int POFF   = $clog2(PBYTES);
  localparam int LANE_W = WOFF - POFF;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic {EMPTY = 1'b0, ACCUM = 1'b1} state_t;

  state_t               state, state_nx;
  logic [ADDR_WIDTH-1:0] pend_addr, pend_addr_nx;
  logic [BUS_WIDTH-1:0]  pend_data, pend_data_nx;
  logic [BYTES-1:0]      pend_be, pend_be_nx;

  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [BUS_WIDTH-1:0]  mem_data [FIFO_DEPTH];
  logic [BYTES-1:0]      mem_be   [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  logic [LANE_W-1:0]     lane;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [BUS_WIDTH-1:0]  lane_data, lane_mask, merged_data;
  logic [BYTES-1:0]      lane_be, merged_be;
  logic                  accept, pop, push, same_word;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [BUS_WIDTH-1:0]  push_data;
  logic [BYTES-1:0]      push_be;

  assign lane      = pix_addr[WOFF-1:POFF];
  assign word_addr = {pix_addr[ADDR_WIDTH-1:WOFF], {WOFF{1'b0}}};
  assign lane_data = {{(BUS_WIDTH-PIXEL_WIDTH){1'b0}}, pix_color} << (int'(lane) * PIXEL_WIDTH);
  assign lane_mask = {{(BUS_WIDTH-PIXEL_WIDTH){1'b0}}, {PIXEL_WIDTH{1'b1}}} << (int'(lane) * PIXEL_WIDTH);
  assign lane_be   = {{(BYTES-PBYTES){1'b0}}, {PBYTES{1'b1}}} << (int'(lane) * PBYTES);
  assign merged_data = (pend_data & ~lane_mask) | lane_data;
  assign merged_be   = pend_be | lane_be;
  assign same_word   = (pend_addr == word_addr);

  // Space check uses only the registered count, so pop never feeds back into pix_ready.
  assign pix_ready = (count < CNT_W'(FIFO_DEPTH));
  assign accept    = pix_valid && pix_ready;
  assign avm_write = (count != {CNT_W{1'b0}});
  assign pop       = avm_write && !avm_waitrequest;
  assign idle      = (state == EMPTY) && (count == {CNT_W{1'b0}});

  assign avm_address    = mem_addr[rd_ptr];
  assign avm_writedata  = mem_data[rd_ptr];
  assign avm_byteenable = mem_be[rd_ptr];

  // Pending-word next state and FIFO push request.
  always_comb begin
    state_nx     = state;
    pend_addr_nx = pend_addr;
    pend_data_nx = pend_data;
    pend_be_nx   = pend_be;
    push         = 1'b0;
    push_addr    = pend_addr;
    push_data    = pend_data;
    push_be      = pend_be;
    if (accept) begin
      case (state)
        EMPTY: begin
          state_nx     = ACCUM;
          pend_addr_nx = word_addr;
          pend_data_nx = lane_data;
          pend_be_nx   = lane_be;
        end
        ACCUM: begin
          if (same_word) begin
            if (&merged_be) begin
              push         = 1'b1;
              push_data    = merged_data;
              push_be      = merged_be;
              state_nx     = EMPTY;
              pend_data_nx = {BUS_WIDTH{1'b0}};
              pend_be_nx   = {BYTES{1'b0}};
            end else begin
              pend_data_nx = merged_data;
              pend_be_nx   = merged_be;
            end
          end else begin
            push         = 1'b1;
            pend_addr_nx = word_addr;
            pend_data_nx = lane_data;
            pend_be_nx   = lane_be;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end else if (flush && (state == ACCUM) && pix_ready) begin
      push         = 1'b1;
      state_nx     = EMPTY;
      pend_data_nx = {BUS_WIDTH{1'b0}};
      pend_be_nx   = {BYTES{1'b0}};
    end else begin
      push = 1'b0;
    end
  end

  // Pending-word register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      pend_addr <= {ADDR_WIDTH{1'b0}};
      pend_data <= {BUS_WIDTH{1'b0}};
      pend_be   <= {BYTES{1'b0}};
    end else begin
      state     <= state_nx;
      pend_addr <= pend_addr_nx;
      pend_data <= pend_data_nx;
      pend_be   <= pend_be_nx;
    end
  end

  // Completed-word FIFO; storage is cleared so the port reads zero during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_addr[i] <= {ADDR_WIDTH{1'b0}};
        mem_data[i] <= {BUS_WIDTH{1'b0}};
        mem_be[i]   <= {BYTES{1'b0}};
      end
    end else begin
      if (push) begin
        mem_addr[wr_ptr] <= push_addr;
        mem_data[wr_ptr] <= push_data;
        mem_be[wr_ptr]   <= push_be;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end else begin
        count <= count;
      end
    end
  end

endmodule

// File: tb/tb_pixel_write_packer.sv
// Directed self-checking bench for pixel_write_packer with default parameters.
module tb_pixel_write_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] pix_addr;
  logic [15:0] pix_color;
  logic        flush;
  logic        idle;
  logic        avm_write;
  logic [31:0] avm_address;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;

  int compared = 0;
  int failed   = 0;

  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  logic [3:0]  log_be   [$];

  pixel_write_packer dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_addr(pix_addr), .pix_color(pix_color), .flush(flush), .idle(idle),
    .avm_write(avm_write), .avm_address(avm_address), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  // Record every accepted Avalon write, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && avm_write && !avm_waitrequest) begin
      log_addr.push_back(avm_address);
      log_data.push_back(avm_writedata);
      log_be.push_back(avm_byteenable);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic [31:0] a, input logic [15:0] c);
    pix_valid = 1'b1;
    pix_addr  = a;
    pix_color = c;
    step();
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (!idle && n < max_cycles) begin
      step();
      n++;
    end
    check("idle_reached", 64'(idle), 64'd1);
  endtask

  task automatic check_log(input string tag, input int idx, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
    if (idx < log_addr.size()) begin
      check({tag, "_addr"}, 64'(log_addr[idx]), 64'(a));
      check({tag, "_data"}, 64'(log_data[idx]), 64'(d));
      check({tag, "_be"}, 64'(log_be[idx]), 64'(be));
    end else begin
      check({tag, "_present"}, 64'(log_addr.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    int base;
    int n;
    logic [31:0] a;
    logic [15:0] c;
    logic [31:0] hold_addr;
    logic [31:0] hold_data;

    reset = 1'b1; pix_valid = 1'b0; pix_addr = 32'h0; pix_color = 16'h0;
    flush = 1'b0; avm_waitrequest = 1'b0;
    #3;
    check("rst_ready", 64'(pix_ready), 64'd1);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_write", 64'(avm_write), 64'd0);
    check("rst_addr", 64'(avm_address), 64'd0);
    check("rst_data", 64'(avm_writedata), 64'd0);
    check("rst_be", 64'(avm_byteenable), 64'd0);
    step(); step();
    reset = 1'b0;
    step();

    // Pair merge
    base = log_addr.size();
    pix_valid = 1'b1; pix_addr = 32'h100; pix_color = 16'h5555;
    step();
    pix_addr = 32'h102; pix_color = 16'hAAAA;
    step();
    pix_valid = 1'b0;
    check("pair_write", 64'(avm_write), 64'd1);
    check("pair_addr_now", 64'(avm_address), 64'h100);
    check("pair_data_now", 64'(avm_writedata), 64'hAAAA5555);
    check("pair_be_now", 64'(avm_byteenable), 64'hF);
    step();
    check("pair_done", 64'(avm_write), 64'd0);
    wait_idle(20);
    check("pair_count", 64'(log_addr.size() - base), 64'd1);
    check_log("pair", base, 32'h100, 32'hAAAA5555, 4'b1111);

    // Word change then flush
    base = log_addr.size();
    pixel(32'h200, 16'hFFFF);
    pixel(32'h206, 16'h1234);
    step();
    check("wc_not_idle", 64'(idle), 64'd0);
    flush = 1'b1;
    wait_idle(20);
    flush = 1'b0;
    step();
    check("wc_count", 64'(log_addr.size() - base), 64'd2);
    check_log("wc0", base, 32'h200, 32'h0000FFFF, 4'b0011);
    check_log("wc1", base + 1, 32'h204, 32'h12340000, 4'b1100);

    // Overwrite
    base = log_addr.size();
    pixel(32'h300, 16'h1111);
    pixel(32'h300, 16'h2222);
    pixel(32'h302, 16'h3333);
    wait_idle(20);
    check("ow_count", 64'(log_addr.size() - base), 64'd1);
    check_log("ow", base, 32'h300, 32'h33332222, 4'b1111);

    // Backpressure: 10 full words while the slave stalls at first
    base = log_addr.size();
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pixel(32'h400 + 32'(4 * (i / 2)) + 32'(2 * (i % 2)),
            (i % 2 == 1) ? 16'(16'hB000 + i / 2) : 16'(16'hA000 + i / 2));
    end
    check("bp_ready_low", 64'(pix_ready), 64'd0);
    check("bp_head_addr", 64'(avm_address), 64'h400);
    check("bp_head_data", 64'(avm_writedata), 64'hB000A000);
    hold_addr = avm_address;
    hold_data = avm_writedata;
    pix_valid = 1'b1; pix_addr = 32'h410; pix_color = 16'hA004;
    step(); step(); step();
    check("bp_ready_still_low", 64'(pix_ready), 64'd0);
    check("bp_stable_write", 64'(avm_write), 64'd1);
    check("bp_stable_addr", 64'(avm_address), 64'(hold_addr));
    check("bp_stable_data", 64'(avm_writedata), 64'(hold_data));
    check("bp_no_write_yet", 64'(log_addr.size() - base), 64'd0);
    avm_waitrequest = 1'b0;
    for (int i = 8; i < 20; i++) begin
      a = 32'h400 + 32'(4 * (i / 2)) + 32'(2 * (i % 2));
      c = (i % 2 == 1) ? 16'(16'hB000 + i / 2) : 16'(16'hA000 + i / 2);
      pix_valid = 1'b1; pix_addr = a; pix_color = c;
      n = 0;
      while (!pix_ready && n < 50) begin
        step();
        n++;
      end
      check("bp_ready_timeout", 64'(pix_ready), 64'd1);
      step();
    end
    pix_valid = 1'b0;
    wait_idle(50);
    check("bp_count", 64'(log_addr.size() - base), 64'd10);
    for (int k = 0; k < 10; k++) begin
      check_log("bp", base + k, 32'h400 + 32'(4 * k),
                {16'(16'hB000 + k), 16'(16'hA000 + k)}, 4'b1111);
    end

    // Flush collides with a merge that completes the word
    base = log_addr.size();
    pixel(32'h500, 16'h7777);
    flush = 1'b1;
    pixel(32'h502, 16'h8888);
    wait_idle(20);
    flush = 1'b0;
    step(); step();
    check("fc_count", 64'(log_addr.size() - base), 64'd1);
    check_log("fc", base, 32'h500, 32'h88887777, 4'b1111);

    // Flush collides with an overwrite: pixel first, flush pushes one cycle later
    base = log_addr.size();
    pixel(32'h600, 16'h1111);
    flush = 1'b1;
    pixel(32'h600, 16'h2222);
    check("fo_no_push_yet", 64'(avm_write), 64'd0);
    check("fo_busy", 64'(idle), 64'd0);
    step();
    check("fo_push_write", 64'(avm_write), 64'd1);
    check("fo_push_data", 64'(avm_writedata), 64'h00002222);
    check("fo_push_be", 64'(avm_byteenable), 64'h3);
    wait_idle(20);
    flush = 1'b0;
    step();
    check("fo_count", 64'(log_addr.size() - base), 64'd1);

    // Reset mid-operation with two words queued and one pending
    base = log_addr.size();
    avm_waitrequest = 1'b1;
    pixel(32'h700, 16'h0001);
    pixel(32'h702, 16'h0002);
    pixel(32'h704, 16'h0003);
    pixel(32'h706, 16'h0004);
    pixel(32'h708, 16'h0005);
    check("mr_write_before", 64'(avm_write), 64'd1);
    check("mr_ready_before", 64'(pix_ready), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mr_write", 64'(avm_write), 64'd0);
    check("mr_ready", 64'(pix_ready), 64'd1);
    check("mr_idle", 64'(idle), 64'd1);
    step();
    #3;
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("mr_no_write", 64'(log_addr.size() - base), 64'd0);
    check("mr_idle_after", 64'(idle), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
